fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage feeding core decode. Drives the rsel/raddr/din/rdata
//  read bus, buffers fetched words with their PCs in a small prefetch queue, and
//  presents them to decode over a valid/ready handshake. Redirects (jump/branch
//  target from writeback) flush the queue and restart fetch at the new PC.
// PARAMETERS
//  DEPTH     2      prefetch queue entries; power of two, >=2
//  RESET_PC  32'h0  first fetch address after reset
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   synchronous, active-high
//  redirect     in   1   flush and restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch PC; bits [1:0] ignored (forced 0)
//  raddr        out  32  read address, word aligned
//  rsel         out  1   read request; held with raddr stable until din
//  din          in   1   read done this cycle, rdata valid
//  rdata        in   32  read data
//  inst_valid   out  1   queue head valid
//  inst         out  32  queue head instruction word
//  inst_pc      out  32  PC of queue head
//  inst_ready   in   1   decode consumes head when inst_valid&&inst_ready
// BEHAVIOUR
//  Reset: rsel=0, raddr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, queue empty,
//   fetch_pc=RESET_PC, state IDLE. Reset mid-request abandons it: rsel=0 next cycle.
//  All outputs registered. At most one bus request outstanding.
//  States: IDLE (rsel=0), REQ (rsel=1, raddr=fetch_pc), DISCARD (rsel=1, result dropped).
//  IDLE -> REQ when count<DEPTH. rsel rises the cycle after reset deasserts.
//  REQ, din=0: hold rsel/raddr. REQ, din=1: push {fetch_pc, rdata}; fetch_pc+=4
//   (mod 2^32, 0xFFFFFFFC wraps to 0); stay REQ with raddr=new fetch_pc if
//   count+1-pop < DEPTH, else IDLE. Queue never overflows.
//  Zero-wait memory + inst_ready=1: one instruction per cycle sustained.
//  Push latency: inst_valid high the cycle after the din cycle (empty queue).
//  Pop: head advances the cycle after inst_valid&&inst_ready; push+pop same
//   cycle keeps count unchanged. inst/inst_pc stable while valid and not popped.
//  Redirect has priority over push, pop and issue:
//   - queue flushed, inst_valid=0 next cycle; fetch_pc = {redirect_pc[31:2],2'b0}
//   - REQ with din=0: -> DISCARD; rsel/raddr held at old address until din,
//     that data dropped, then REQ at new fetch_pc next cycle.
//   - din=1 same cycle: data dropped, REQ at new fetch_pc next cycle.
//   - IDLE: REQ at new fetch_pc next cycle. DISCARD: stay DISCARD, update fetch_pc.
//   - Pop in the redirect cycle has no effect beyond the flush.
// TESTING
//  1 Reset, zero-wait memory rdata=raddr^32'hA5A50000, inst_ready=1 -> raddr 0,4,8..
//    on consecutive cycles; inst_pc 0,4,8 with inst 32'hA5A50000,32'hA5A50004,...
//  2 inst_ready=0, DEPTH=2 -> exactly two din handshakes (0,4) then rsel=0;
//    raise inst_ready -> inst_pc 0 then 4, rsel reasserts with raddr=8.
//  3 Memory asserts din 3 cycles after rsel -> raddr/rsel stable 4 cycles, one
//    push, inst_valid the cycle after din.
//  4 Redirect to 32'h103 while request to 8 pending -> rsel held at raddr=8 until
//    din, data dropped, next raddr=32'h100, first inst_pc=32'h100.
//  5 Redirect to 32'hFFFFFFFC coincident with din and pop -> inst_valid=0 next
//    cycle, no stale word; fetches 32'hFFFFFFFC then 0.
//  6 Reset asserted mid-request and with 2 queued -> next cycle rsel=0,
//    inst_valid=0, raddr=RESET_PC; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues single-outstanding reads on the rsel/din bus,
// buffers {pc, word} pairs in a small queue and hands them to decode via valid/ready.
module fetch_unit #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] raddr,
   output logic        rsel,
   input  logic        din,
   input  logic [31:0] rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            rsel_q, rsel_d;
   logic [31:0]     raddr_q, raddr_d;
   logic            inst_valid_q, inst_valid_d;
   logic [31:0]     inst_q, inst_d;
   logic [31:0]     inst_pc_q, inst_pc_d;
   logic [31:0]     pc_mem_q   [DEPTH];
   logic [31:0]     data_mem_q [DEPTH];
   logic            push, pop;
   logic            unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      push         = 1'b0;
      pop          = inst_valid_q && inst_ready;

      if (redirect) begin
         // Flush wins over everything; an in-flight read must still complete on the bus.
         fetch_pc_d   = {redirect_pc[31:2], 2'b00};
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         count_d      = '0;
         inst_valid_d = 1'b0;
         pop          = 1'b0;
         case (state_q)
            REQ, DISCARD: state_d = din ? REQ : DISCARD;
            default:      state_d = REQ;
         endcase
      end else begin
         case (state_q)
            IDLE: begin
               if (count_q < CW'(DEPTH)) state_d = REQ;
            end
            REQ: begin
               if (din) begin
                  push       = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  if (pop) state_d = (count_q < CW'(DEPTH)) ? REQ : IDLE;
                  else     state_d = ({1'b0, count_q} + (CW+1)'(1) < (CW+1)'(DEPTH)) ? REQ : IDLE;
               end
            end
            DISCARD: begin
               if (din) state_d = REQ;
            end
            default: state_d = IDLE;
         endcase

         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase

         // Head register: take the incoming word directly when nothing older remains.
         inst_valid_d = (count_d != '0);
         if (count_d != '0) begin
            if (count_q == CW'(pop)) begin
               inst_d    = rdata;
               inst_pc_d = fetch_pc_q;
            end else begin
               inst_d    = data_mem_q[rd_ptr_d];
               inst_pc_d = pc_mem_q[rd_ptr_d];
            end
         end
      end

      rsel_d  = (state_d != IDLE);
      raddr_d = (state_d == DISCARD) ? raddr_q : fetch_pc_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_PC;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         rsel_q       <= 1'b0;
         raddr_q      <= RESET_PC;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         rsel_q       <= rsel_d;
         raddr_q      <= raddr_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !redirect && !reset) begin
         pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
         data_mem_q[wr_ptr_q] <= rdata;
      end
   end

   assign rsel       = rsel_q;
   assign raddr      = raddr_q;
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;

endmodule
